pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic, parametrised pipeline stage register for the five-stage MIPS core. It replaces per-stage hand-written registers (F/D, D/E, E/M, M/W) with one block that carries a packed payload of control and datapath fields. The block adds a valid/ready handshake, flush-to-bubble, and an optional two-entry skid mode, so stalls no longer need a combinational enable chain across stages. Each pipeline boundary instantiates one copy; the hazard unit drives `Flush`.

## Interface
Parameters:
- `WIDTH`, 64: payload width in bits (packed control + datapath fields).
- `SKID`, 1: 1 = two-entry skid buffer with registered `InReady`; 0 = single entry with combinational `InReady`.

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Clr`  in  1  reset; synchronous, active-high.
- `Flush`  in  1  discard all held beats and the incoming beat this cycle.
- `InValid`  in  1  upstream beat present.
- `InReady`  out  1  stage can accept a beat.
- `InData`  in  WIDTH  upstream payload.
- `OutValid`  out  1  beat presented downstream.
- `OutReady`  in  1  downstream accepts.
- `OutData`  out  WIDTH  payload; all-zero (bubble) whenever `OutValid`=0.
- `Occupancy`  out  2  number of held beats, 0..2 (0..1 when `SKID`=0).

## Operation
- Handshake terms:
  - accept = `InValid & InReady`.
  - pop = `OutValid & OutReady`.
- `InData` is sampled only on accept. `OutData`/`OutValid` come from the main register; the skid register is never visible.
- Bubble rule: when the main entry empties (pop with nothing to refill it, `Flush`, or `Clr`), the main data register is loaded with zero. All control fields therefore read inert (no RegWrite/MemWrite).
- State machine (`SKID`=1): EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE (main <= `InData`).
  - ONE:
    - accept & pop -> ONE (main <= `InData`).
    - accept & ~pop -> TWO (skid <= `InData`).
    - pop & ~accept -> EMPTY (main <= 0).
  - TWO:
    - pop -> ONE (main <= skid, skid <= 0).
    - No accept is possible in TWO.
- `SKID`=0: states EMPTY and ONE only. TWO is unreachable.
- `InReady`:
  - `SKID`=1: registered, = (state != TWO).
  - `SKID`=0: = ~`OutValid` | `OutReady` (combinational).
- Priority: `Clr` > `Flush` > handshake.
  - Either one forces EMPTY, zeroes both data registers, and drops any beat accepted that cycle.
  - A simultaneous pop still completes downstream: the beat was presented and taken.
- `Occupancy` = 0/1/2 for EMPTY/ONE/TWO.
- The protocol obeys standard valid/ready rules.
  - Once `OutValid` is asserted, `OutData` is stable until pop, `Flush` or `Clr`.
  - `InValid` is never gated by `InReady`.

## Timing
- Reset values (cycle after `Clr`=1):
  - `OutValid`=0, `OutData`=0, `Occupancy`=0.
  - `InReady`=1 (both modes; in `SKID`=0 because `OutValid`=0).
  - Skid register = 0.
- Latency: a beat accepted at edge N is on `OutData` with `OutValid`=1 after edge N.
- Throughput: one beat per cycle when `OutReady` is held high, in both modes.
- `SKID`=1 with `OutReady` dropping at cycle N:
  - A beat accepted at edge N+1 lands in skid.
  - `InReady` is low from after edge N+1 until the first pop.
  - No beat is lost or duplicated.
- `Flush` takes effect at the same edge. The cycle after, `OutValid`=0 and `InReady`=1.
- `Clr` or `Flush` while in TWO: both beats are dropped in one edge.

## Structure
- Shared package `pipe_pkg`:
  - State enum `pipe_state_t` {EMPTY, ONE, TWO}.
  - Occupancy constants.
  - Packed payload typedefs per boundary, e.g. `de_payload_t` with RegWrite, MemtoReg, MemWrite, ALUControl[3:0], ALUSrc[1:0], RegDst, StartMult, MultSign, OutSelect[1:0], jump, isBranch, PCSrc, PC, PCBranch, PCPlus4, Rd1, Rd2, Rs, Rt, Rd, SEimm, ZEimm, ZPimm.
- One sub-module, `pipe_data_reg`: a WIDTH-bit register with load and synchronous zero. It is instantiated twice, for the main and skid entries.
- The state machine and handshake logic live in `pipe_stage_reg`.

## Test plan
- Reset: assert `Clr` with `InValid`=1, `InData`=0xDEAD -> next cycle `OutValid`=0, `OutData`=0, `InReady`=1, `Occupancy`=0.
- Streaming: `OutReady`=1, feed 0x1..0x8 on consecutive cycles -> `OutData` shows 0x1..0x8, each one cycle after accept, with no gaps.
- Backpressure (`SKID`=1): stream 0x10, 0x11, 0x12 and drop `OutReady` after 0x10 pops.
  - 0x11 is held on `OutData` and 0x12 goes to skid; `InReady`=0, `Occupancy`=2.
  - Raise `OutReady` -> 0x11 then 0x12 pop in order.
- Flush in TWO: `Occupancy`=2, assert `Flush` with `InValid`=1, `InData`=0x99 -> next cycle `Occupancy`=0, `OutData`=0; 0x99 never appears.
- Bubble on drain: single beat 0x5A popped with no refill -> next cycle `OutValid`=0 and `OutData`=0.
- `SKID`=0: hold `OutReady`=0 with one beat held -> `InReady`=0 in the same cycle; raising `OutReady` raises `InReady` combinationally and the new beat replaces the popped one at the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline boundary registers: state encoding, occupancy
// codes and the packed payloads carried across each stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef struct packed {
    logic [31:0] Instr;
    logic [31:0] PCPlus4;
  } fd_payload_t;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemWrite;
    logic [3:0]  ALUControl;
    logic [1:0]  ALUSrc;
    logic        RegDst;
    logic        StartMult;
    logic        MultSign;
    logic [1:0]  OutSelect;
    logic        jump;
    logic        isBranch;
    logic        PCSrc;
    logic [31:0] PC;
    logic [31:0] PCBranch;
    logic [31:0] PCPlus4;
    logic [31:0] Rd1;
    logic [31:0] Rd2;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [31:0] SEimm;
    logic [31:0] ZEimm;
    logic [31:0] ZPimm;
  } de_payload_t;

  localparam int FD_WIDTH = $bits(fd_payload_t);
  localparam int DE_WIDTH = $bits(de_payload_t);

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      ONE:     occ_of = OCC_ONE;
      TWO:     occ_of = OCC_TWO;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable; synchronous zero wins over load
// so an emptied entry always reads as a bubble.
module pipe_data_reg #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             i_load,
  input  logic             i_zero,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge Clk) begin
    if (i_zero)
      r_q <= '0;
    else if (i_load)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush-to-bubble and
// an optional second (skid) entry that lets InReady be registered.
//
// state | meaning
// EMPTY | nothing held, OutValid=0, OutData=0
// ONE   | one beat in main entry, presented downstream
// TWO   | main presented, next beat parked in skid; InReady=0 (SKID=1 only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy
);

  localparam bit LP_SKID = (SKID != 0);

  pipe_state_t      r_state;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [1:0]       r_occ;

  pipe_state_t      w_next;
  logic             w_kill;
  logic             w_accept;
  logic             w_pop;
  logic             w_main_load;
  logic             w_main_zero;
  logic             w_skid_load;
  logic             w_skid_zero;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_kill   = Clr | Flush;
  assign InReady  = LP_SKID ? r_in_ready : (~r_out_valid | OutReady);
  assign w_accept = InValid & InReady;
  assign w_pop    = r_out_valid & OutReady;

  always_comb begin
    w_next      = r_state;
    w_main_load = 1'b0;
    w_main_zero = 1'b0;
    w_skid_load = 1'b0;
    w_skid_zero = 1'b0;
    w_main_d    = InData;
    if (w_kill) begin
      w_next      = EMPTY;
      w_main_zero = 1'b1;
      w_skid_zero = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_next      = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_accept && LP_SKID) begin
            w_next      = TWO;
            w_skid_load = 1'b1;
          end else if (w_pop) begin
            w_next      = EMPTY;
            w_main_zero = 1'b1;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_next      = ONE;
            w_main_load = 1'b1;
            w_main_d    = w_skid_q;
            w_skid_zero = 1'b1;
          end
        end
        default: begin
          w_next      = EMPTY;
          w_main_zero = 1'b1;
          w_skid_zero = 1'b1;
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they never glitch.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state     <= EMPTY;
      r_occ       <= OCC_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_occ       <= occ_of(w_next);
      r_out_valid <= (w_next != EMPTY);
      r_in_ready  <= (w_next != TWO);
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .Clk    (Clk),
    .i_load (w_main_load),
    .i_zero (w_main_zero),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .Clk    (Clk),
    .i_load (w_skid_load),
    .i_zero (w_skid_zero),
    .i_d    (InData),
    .o_q    (w_skid_q)
  );

  assign OutValid  = r_out_valid;
  assign OutData   = w_main_q;
  assign Occupancy = r_occ;

endmodule
